vc_input_buffer: RTL and testbench
==================================

Name: vc_input_buffer

Overview:
- Parametrised multi-virtual-channel input buffer for the NOC router input port; successor to the single-queue 16-bit/8-deep input buffer.
- Holds VC_COUNT independent FIFOs of DEPTH flits each, DATA_WIDTH bits per flit, in one RAM partitioned by VC.
- Link side writes flits tagged with a VC. Switch/arbiter side reads from any VC. Output is registered; per-VC empty/full flags drive credit and arbitration logic.

Parameters:
- DATA_WIDTH, 16, flit width in bits.
- DEPTH, 8, flits per VC; power of 2, >= 2.
- VC_COUNT, 2, number of virtual channels; >= 1.
- Derived: PTR_W = clog2(DEPTH); VC_W = max(1, clog2(VC_COUNT)); ADDR_W = VC_W + PTR_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- buf_data_i  in  DATA_WIDTH  write flit.
- buf_write_i  in  1  write request.
- buf_wvc_i  in  VC_W  target VC for the write.
- buf_read_i  in  1  read request.
- buf_rvc_i  in  VC_W  source VC for the read.
- buf_empty_o  out  VC_COUNT  per-VC empty flag (bit v = VC v).
- buf_full_o  out  VC_COUNT  per-VC full flag.
- buf_valid_o  out  1  buf_data_o/buf_vc_o hold a read result this cycle.
- buf_data_o  out  DATA_WIDTH  read flit.
- buf_vc_o  out  VC_W  VC the current buf_data_o came from.
- buf_overflow_o  out  1  sticky: a write to a full VC occurred.
- buf_underflow_o  out  1  sticky: a read from an empty VC occurred.
- buf_ram_raddr_o  out  ADDR_W  physical address of the last accepted read, {vc, rptr}.
- buf_ram_waddr_o  out  ADDR_W  physical address of the last accepted write, {vc, wptr}.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All rptr, wptr and counts go to 0.
  - buf_empty_o all 1s; buf_full_o all 0s.
  - buf_valid_o, buf_data_o, buf_vc_o, both sticky flags and both ram addresses go to 0.
  - RAM contents are not cleared.
  - Reset mid-traffic discards all queued flits; requests in the reset cycle are ignored.
- Per-VC state: rptr[PTR_W], wptr[PTR_W], count[PTR_W+1]. empty = (count==0); full = (count==DEPTH). Both flags are combinational from the registered count.
- Write accept: buf_write_i && !full[buf_wvc_i].
  - RAM[{wvc, wptr}] <= buf_data_i; wptr increments, wrapping modulo DEPTH; buf_ram_waddr_o <= {wvc, wptr_old}.
  - Rejected write: no state change except buf_overflow_o <= 1.
- Read accept: buf_read_i && !empty[buf_rvc_i].
  - Next cycle: buf_valid_o=1, buf_data_o=RAM[{rvc, rptr_old}], buf_vc_o=rvc. Latency is exactly 1 cycle.
  - rptr increments with wrap; buf_ram_raddr_o <= {rvc, rptr_old}.
  - Rejected read: buf_valid_o=0 next cycle, buf_underflow_o <= 1.
- Idle cycle (no accepted read): buf_valid_o=0; buf_data_o and buf_vc_o hold their previous values.
- Count update per VC: +1 on accepted write only; -1 on accepted read only; unchanged when both are accepted on that VC.
- Simultaneous read and write, same VC:
  - VC empty: write accepted, read rejected (no bypass, underflow set). Flit becomes readable the next cycle.
  - VC full: read accepted, write rejected (no pass-through, overflow set). Full deasserts the following cycle.
  - Otherwise both accepted; count unchanged.
- Simultaneous read and write on different VCs are independent.
- Out-of-range VC index (>= VC_COUNT): request is ignored; no flag is set.
- Sticky flags clear only on reset.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> buf_empty_o=2'b11, buf_full_o=2'b00, buf_valid_o=0, both sticky flags 0.
- Single flit: write 16'h8000 to VC0; read VC0 the next cycle -> buf_valid_o=1 one cycle after the read, buf_data_o=16'h8000, buf_vc_o=0, buf_ram_raddr_o=4'b0000; VC0 empty again.
- Fill and wrap: write 8 flits 0x0001..0x0008 to VC1 -> buf_full_o[1]=1. A ninth write (0x0009) -> buf_overflow_o=1, data discarded. Read 8 -> 0x0001..0x0008 in order. Then write/read 3 more -> waddr wraps 4'b1111 -> 4'b1000.
- Interleaved VCs: alternate writes A0..A3 to VC0 and B0..B3 to VC1; read VC1,VC0,VC1,... -> B0,A0,B1,A1...; each buf_vc_o matches its flit.
- Simultaneous boundaries: read+write VC0 while empty -> write accepted, buf_valid_o=0 next cycle, underflow=1. Fill VC0, then read+write VC0 -> oldest flit out, write dropped, overflow=1, count=7.
- Reset mid-operation: VC0 holds 3 flits, read pending; assert reset for 1 cycle -> buf_valid_o=0, empty=2'b11; a subsequent read of VC0 is rejected.

Source files
------------

// File: rtl/vc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vc_input_buffer: per-VC FIFOs sharing one RAM, registered read port.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vc_input_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int VC_COUNT   = 2,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int VC_W      = (VC_COUNT > 1) ? $clog2(VC_COUNT) : 1,
  localparam int ADDR_W    = VC_W + PTR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  input  logic                  buf_write_i,
  input  logic [VC_W-1:0]       buf_wvc_i,
  input  logic                  buf_read_i,
  input  logic [VC_W-1:0]       buf_rvc_i,
  output logic [VC_COUNT-1:0]   buf_empty_o,
  output logic [VC_COUNT-1:0]   buf_full_o,
  output logic                  buf_valid_o,
  output logic [DATA_WIDTH-1:0] buf_data_o,
  output logic [VC_W-1:0]       buf_vc_o,
  output logic                  buf_overflow_o,
  output logic                  buf_underflow_o,
  output logic [ADDR_W-1:0]     buf_ram_raddr_o,
  output logic [ADDR_W-1:0]     buf_ram_waddr_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_W)-1];

  logic [PTR_W-1:0]    rptr  [VC_COUNT];
  logic [PTR_W-1:0]    wptr  [VC_COUNT];
  logic [PTR_W:0]      count [VC_COUNT];

  logic [VC_COUNT-1:0] wr_sel;
  logic [VC_COUNT-1:0] rd_sel;
  logic [VC_COUNT-1:0] wr_acc;
  logic [VC_COUNT-1:0] rd_acc;
  logic [PTR_W-1:0]    wptr_sel;
  logic [PTR_W-1:0]    rptr_sel;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   raddr;
  logic                any_wr;
  logic                any_rd;

  // Out-of-range VC indices match no lane, so they fall through as no-ops.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    wptr_sel = '0;
    rptr_sel = '0;
    for (int v = 0; v < VC_COUNT; v++) begin
      if (buf_write_i && (buf_wvc_i == VC_W'(v))) begin
        wr_sel[v] = 1'b1;
        wptr_sel  = wptr[v];
      end
      if (buf_read_i && (buf_rvc_i == VC_W'(v))) begin
        rd_sel[v] = 1'b1;
        rptr_sel  = rptr[v];
      end
    end
  end

  for (genvar v = 0; v < VC_COUNT; v++) begin : g_flags
    assign buf_empty_o[v] = (count[v] == '0);
    assign buf_full_o[v]  = (count[v] == FULL_CNT);
  end

  // Flags come from registered counts: no empty bypass, no full pass-through.
  assign wr_acc = wr_sel & ~buf_full_o;
  assign rd_acc = rd_sel & ~buf_empty_o;
  assign any_wr = |wr_acc;
  assign any_rd = |rd_acc;
  assign waddr  = {buf_wvc_i, wptr_sel};
  assign raddr  = {buf_rvc_i, rptr_sel};

  always_ff @(posedge clk) begin
    if (reset && any_wr) begin
      mem[waddr] <= buf_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        rptr[v]  <= '0;
        wptr[v]  <= '0;
        count[v] <= '0;
      end
      buf_valid_o     <= 1'b0;
      buf_data_o      <= '0;
      buf_vc_o        <= '0;
      buf_overflow_o  <= 1'b0;
      buf_underflow_o <= 1'b0;
      buf_ram_raddr_o <= '0;
      buf_ram_waddr_o <= '0;
    end else begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (wr_acc[v]) wptr[v] <= wptr[v] + 1'b1;
        if (rd_acc[v]) rptr[v] <= rptr[v] + 1'b1;
        if (wr_acc[v] && !rd_acc[v]) begin
          count[v] <= count[v] + 1'b1;
        end else if (rd_acc[v] && !wr_acc[v]) begin
          count[v] <= count[v] - 1'b1;
        end
      end
      buf_valid_o <= any_rd;
      if (any_rd) begin
        buf_data_o      <= mem[raddr];
        buf_vc_o        <= buf_rvc_i;
        buf_ram_raddr_o <= raddr;
      end
      if (any_wr) begin
        buf_ram_waddr_o <= waddr;
      end
      if (|(wr_sel & buf_full_o))  buf_overflow_o  <= 1'b1;
      if (|(rd_sel & buf_empty_o)) buf_underflow_o <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vc_input_buffer: scoreboard bench for vc_input_buffer (2 VCs x 8).    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vc_input_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] buf_data_i = '0;
  logic        buf_write_i = 1'b0;
  logic        buf_wvc_i = 1'b0;
  logic        buf_read_i = 1'b0;
  logic        buf_rvc_i = 1'b0;
  logic [1:0]  buf_empty_o;
  logic [1:0]  buf_full_o;
  logic        buf_valid_o;
  logic [15:0] buf_data_o;
  logic        buf_vc_o;
  logic        buf_overflow_o;
  logic        buf_underflow_o;
  logic [3:0]  buf_ram_raddr_o;
  logic [3:0]  buf_ram_waddr_o;

  vc_input_buffer #(.DATA_WIDTH(16), .DEPTH(8), .VC_COUNT(2)) dut (
    .clk(clk), .reset(reset),
    .buf_data_i(buf_data_i), .buf_write_i(buf_write_i), .buf_wvc_i(buf_wvc_i),
    .buf_read_i(buf_read_i), .buf_rvc_i(buf_rvc_i),
    .buf_empty_o(buf_empty_o), .buf_full_o(buf_full_o),
    .buf_valid_o(buf_valid_o), .buf_data_o(buf_data_o), .buf_vc_o(buf_vc_o),
    .buf_overflow_o(buf_overflow_o), .buf_underflow_o(buf_underflow_o),
    .buf_ram_raddr_o(buf_ram_raddr_o), .buf_ram_waddr_o(buf_ram_waddr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per VC, plus the expected read-result stream.
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [16:0] exp_q[$];
  logic        exp_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [16:0] e;

  task automatic model_clear();
    mq0.delete(); mq1.delete(); exp_q.delete();
    exp_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic step(input logic wr, input logic wvc, input logic [15:0] d,
                      input logic rd, input logic rvc);
    int  wsz, rsz;
    bit  wacc, racc;
    buf_write_i = wr; buf_wvc_i = wvc; buf_data_i = d;
    buf_read_i  = rd; buf_rvc_i = rvc;
    wsz  = wvc ? mq1.size() : mq0.size();
    rsz  = rvc ? mq1.size() : mq0.size();
    wacc = wr && (wsz < 8);
    racc = rd && (rsz > 0);
    @(posedge clk); #1;
    if (racc) begin
      if (rvc) exp_q.push_back({1'b1, mq1.pop_front()});
      else     exp_q.push_back({1'b0, mq0.pop_front()});
    end
    if (wacc) begin
      if (wvc) mq1.push_back(d);
      else     mq0.push_back(d);
    end
    exp_valid = racc;
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && !racc) m_unf = 1'b1;
    buf_write_i = 1'b0; buf_read_i = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input logic rd_during);
    reset = 1'b0; buf_read_i = rd_during; buf_rvc_i = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset(2, 1'b0);
    reset = 1'b1;
    model_clear();
    checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL reset_empty got %b expected 11", buf_empty_o); end
    checks++; if (buf_full_o !== 2'b00) begin errors++; $display("FAIL reset_full got %b expected 00", buf_full_o); end
    checks++; if (buf_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", buf_valid_o); end
    checks++; if ({buf_overflow_o, buf_underflow_o} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b expected 00", {buf_overflow_o, buf_underflow_o}); end
    checks++; if ({buf_ram_raddr_o, buf_ram_waddr_o, buf_data_o} !== 24'h0) begin errors++; $display("FAIL reset_regs got %h expected 0", {buf_ram_raddr_o, buf_ram_waddr_o, buf_data_o}); end
  endtask

  task automatic test_single();
    step(1'b1, 1'b0, 16'h8000, 1'b0, 1'b0);
    checks++; if (buf_empty_o !== 2'b10) begin errors++; $display("FAIL single_empty_after_wr got %b expected 10", buf_empty_o); end
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL single_valid got %b expected 1", buf_valid_o); end
    else begin
      e = exp_q.pop_front();
      checks++; if ({buf_vc_o, buf_data_o} !== e || e !== 17'h08000) begin errors++; $display("FAIL single_data got %h expected %h", {buf_vc_o, buf_data_o}, e); end
    end
    checks++; if (buf_ram_raddr_o !== 4'b0000) begin errors++; $display("FAIL single_raddr got %b expected 0000", buf_ram_raddr_o); end
    checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL single_empty_after_rd got %b expected 11", buf_empty_o); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 16'(i), 1'b0, 1'b0);
    checks++; if (buf_full_o !== 2'b10) begin errors++; $display("FAIL fill_full got %b expected 10", buf_full_o); end
    checks++; if (buf_ram_waddr_o !== 4'b1111) begin errors++; $display("FAIL fill_waddr got %b expected 1111", buf_ram_waddr_o); end
    step(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0);
    checks++; if (buf_overflow_o !== m_ovf || !m_ovf) begin errors++; $display("FAIL fill_overflow got %b expected 1", buf_overflow_o); end
    checks++; if (buf_ram_waddr_o !== 4'b1111) begin errors++; $display("FAIL fill_rejected_waddr got %b expected 1111", buf_ram_waddr_o); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL drain_valid[%0d] got %b expected 1", i, buf_valid_o); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({buf_vc_o, buf_data_o} !== e || e[15:0] !== 16'(i + 1)) begin errors++; $display("FAIL drain_data[%0d] got %h expected %h", i, {buf_vc_o, buf_data_o}, e); end
      end
      checks++; if (buf_ram_raddr_o !== {1'b1, 3'(i)}) begin errors++; $display("FAIL drain_raddr[%0d] got %b expected %b", i, buf_ram_raddr_o, {1'b1, 3'(i)}); end
    end
    checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL drain_empty got %b expected 11", buf_empty_o); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 16'h00A0 + 16'(k), 1'b0, 1'b0);
      checks++; if (buf_ram_waddr_o !== {1'b1, 3'(k)}) begin errors++; $display("FAIL wrap_waddr[%0d] got %b expected %b", k, buf_ram_waddr_o, {1'b1, 3'(k)}); end
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL wrap_valid[%0d] got %b expected 1", k, buf_valid_o); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({buf_vc_o, buf_data_o} !== e) begin errors++; $display("FAIL wrap_data[%0d] got %h expected %h", k, {buf_vc_o, buf_data_o}, e); end
      end
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0, 1'b0);
      step(1'b1, 1'b1, 16'hB000 + 16'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      // Odd reads also write VC1 to exercise independent cross-VC traffic.
      step(i[0], 1'b1, 16'hC000 + 16'(i), 1'b1, ~i[0]);
      checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL ilv_valid[%0d] got %b expected 1", i, buf_valid_o); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({buf_vc_o, buf_data_o} !== e || e[16] !== ~i[0]) begin errors++; $display("FAIL ilv_data[%0d] got %h expected %h", i, {buf_vc_o, buf_data_o}, e); end
      end
    end
  endtask

  task automatic test_simul_boundaries();
    apply_reset(1, 1'b0);
    reset = 1'b1;
    model_clear();
    step(1'b1, 1'b0, 16'h1111, 1'b1, 1'b0);
    checks++; if (buf_valid_o !== exp_valid || exp_valid) begin errors++; $display("FAIL sim_empty_valid got %b expected 0", buf_valid_o); end
    checks++; if (buf_underflow_o !== m_unf || !m_unf) begin errors++; $display("FAIL sim_underflow got %b expected 1", buf_underflow_o); end
    checks++; if (buf_empty_o[0] !== 1'b0) begin errors++; $display("FAIL sim_wr_accepted got %b expected 0", buf_empty_o[0]); end
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 16'h1111 + 16'(i), 1'b0, 1'b0);
    checks++; if (buf_full_o !== 2'b01) begin errors++; $display("FAIL sim_full got %b expected 01", buf_full_o); end
    checks++; if (buf_overflow_o !== 1'b0) begin errors++; $display("FAIL sim_no_overflow_yet got %b expected 0", buf_overflow_o); end
    step(1'b1, 1'b0, 16'hDEAD, 1'b1, 1'b0);
    checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL sim_full_valid got %b expected 1", buf_valid_o); end
    else begin
      e = exp_q.pop_front();
      checks++; if ({buf_vc_o, buf_data_o} !== e || e !== 17'h01111) begin errors++; $display("FAIL sim_full_data got %h expected %h", {buf_vc_o, buf_data_o}, e); end
    end
    checks++; if (buf_overflow_o !== m_ovf || !m_ovf) begin errors++; $display("FAIL sim_overflow got %b expected 1", buf_overflow_o); end
    checks++; if (buf_full_o !== 2'b00 || buf_empty_o[0] !== 1'b0) begin errors++; $display("FAIL sim_count7 got full %b empty %b expected full 00 empty0 0", buf_full_o, buf_empty_o); end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      checks++; if (buf_valid_o !== exp_valid || !exp_valid) begin errors++; $display("FAIL sim_drain_valid[%0d] got %b expected 1", i, buf_valid_o); end
      else begin
        e = exp_q.pop_front();
        checks++; if ({buf_vc_o, buf_data_o} !== e) begin errors++; $display("FAIL sim_drain_data[%0d] got %h expected %h", i, {buf_vc_o, buf_data_o}, e); end
      end
    end
    checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL sim_drained got %b expected 11", buf_empty_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h5550 + 16'(i), 1'b0, 1'b0);
    apply_reset(1, 1'b1);
    checks++; if (buf_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b expected 0", buf_valid_o); end
    checks++; if (buf_empty_o !== 2'b11) begin errors++; $display("FAIL mid_empty got %b expected 11", buf_empty_o); end
    checks++; if ({buf_data_o, buf_overflow_o, buf_underflow_o} !== 18'h0) begin errors++; $display("FAIL mid_regs got %h expected 0", {buf_data_o, buf_overflow_o, buf_underflow_o}); end
    reset = 1'b1; buf_read_i = 1'b0;
    model_clear();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    checks++; if (buf_valid_o !== exp_valid || exp_valid) begin errors++; $display("FAIL mid_read_valid got %b expected 0", buf_valid_o); end
    checks++; if (buf_underflow_o !== m_unf || !m_unf) begin errors++; $display("FAIL mid_read_underflow got %b expected 1", buf_underflow_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_interleave();
    test_simul_boundaries();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
